// File: rtl/nios_system_sysid_checker_if.sv
// ---------------------------------------------------------------------------
// nios_system_sysid_checker_if
// Private point-to-point read port between the system ID slave and its
// boot-time checker. The checker (master) drives the word address; the
// stateless sysid slave (slave) returns the addressed 32-bit word.
// ---------------------------------------------------------------------------
interface nios_system_sysid_checker_if;
   logic        sysid_address;
   logic [31:0] sysid_readdata;

   modport master (
      output sysid_address,
      input  sysid_readdata
   );

   modport slave (
      input  sysid_address,
      output sysid_readdata
   );
endinterface : nios_system_sysid_checker_if

// File: rtl/nios_system_sysid_checker.sv
// ---------------------------------------------------------------------------
// nios_system_sysid_checker
// Boot-time consumer of the system ID slave. Reads the ID word (address 0)
// and the timestamp word (address 1), captures both and compares them with
// the build-time expected values, giving hardware an "image matches this
// FPGA build" flag before the CPU is released.
//
// Optional feature macro: SYSID_CHECK_IRQ_EN
//   defined   -> irq / irq_clear ports and a level mismatch interrupt
//   undefined -> no interrupt ports or logic; behaviour otherwise identical
//
// READ_LATENCY is the number of cycles from an address change to valid
// readdata (0..15); only its low four bits are used by the 4-bit counter.
// ---------------------------------------------------------------------------
module nios_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID  = 32'd0,
   parameter logic [31:0] EXPECTED_TS  = 32'd1346454757,
   parameter int unsigned READ_LATENCY = 0,
   parameter bit          AUTO_START   = 1'b1
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic                                start,
   output logic                                busy,
   output logic                                done,
   output logic                                id_ok,
   output logic                                ts_ok,
   output logic [31:0]                         id_value,
   output logic [31:0]                         ts_value,
   nios_system_sysid_checker_if.master         sysid
`ifdef SYSID_CHECK_IRQ_EN
   ,
   output logic                                irq,
   input  logic                                irq_clear
`endif
);

   // Sample point inside each read state: the counter value at which the
   // slave's readdata has settled after the registered address change.
   localparam logic [3:0] LAT_C = 4'(READ_LATENCY);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_START_PEND = 3'd1,
      ST_RD_ID      = 3'd2,
      ST_RD_TS      = 3'd3,
      ST_FINISH     = 3'd4
   } state_t;

   // Full 32-bit equality between a captured word and its expected value;
   // no bits are masked, any single-bit difference is a mismatch.
   function automatic logic word_match(input logic [31:0] observed,
                                       input logic [31:0] expected);
      return (observed == expected) ? 1'b1 : 1'b0;
   endfunction

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic        busy_r;
   logic        done_r;
   logic        id_ok_r;
   logic        ts_ok_r;
   logic [31:0] id_value_r;
   logic [31:0] ts_value_r;
   logic        address_r;

   logic        sample_point_s;
   logic        id_sample_s;
   logic        ts_sample_s;
   logic        id_ok_next_s;
   logic        ts_ok_next_s;

   // Decode the read-state sample points and the compare results that become
   // visible at the edge entering FINISH (timestamp compared straight off the bus).
   always_comb begin
      sample_point_s = (cnt_r == LAT_C) ? 1'b1 : 1'b0;
      id_sample_s    = ((state_r == ST_RD_ID) && sample_point_s) ? 1'b1 : 1'b0;
      ts_sample_s    = ((state_r == ST_RD_TS) && sample_point_s) ? 1'b1 : 1'b0;
      id_ok_next_s   = word_match(id_value_r, EXPECTED_ID);
      ts_ok_next_s   = word_match(sysid.sysid_readdata, EXPECTED_TS);
   end

   // Check sequencer: state, latency counter, captured words and all
   // status outputs are registered here. Reset forces every output to 0,
   // so busy only rises at the edge that leaves START_PEND for RD_ID.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= AUTO_START ? ST_START_PEND : ST_IDLE;
         cnt_r      <= 4'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         id_ok_r    <= 1'b0;
         ts_ok_r    <= 1'b0;
         id_value_r <= 32'd0;
         ts_value_r <= 32'd0;
         address_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r    <= ST_RD_ID;
                  cnt_r      <= 4'd0;
                  busy_r     <= 1'b1;
                  address_r  <= 1'b0;
                  id_ok_r    <= 1'b0;
                  ts_ok_r    <= 1'b0;
                  id_value_r <= 32'd0;
                  ts_value_r <= 32'd0;
               end else begin
                  busy_r     <= 1'b0;
               end
            end
            ST_START_PEND: begin
               state_r   <= ST_RD_ID;
               cnt_r     <= 4'd0;
               busy_r    <= 1'b1;
               address_r <= 1'b0;
            end
            ST_RD_ID: begin
               if (id_sample_s) begin
                  id_value_r <= sysid.sysid_readdata;
                  state_r    <= ST_RD_TS;
                  cnt_r      <= 4'd0;
                  address_r  <= 1'b1;
               end else begin
                  cnt_r      <= cnt_r + 4'd1;
               end
            end
            ST_RD_TS: begin
               if (ts_sample_s) begin
                  ts_value_r <= sysid.sysid_readdata;
                  id_ok_r    <= id_ok_next_s;
                  ts_ok_r    <= ts_ok_next_s;
                  done_r     <= 1'b1;
                  state_r    <= ST_FINISH;
                  cnt_r      <= 4'd0;
               end else begin
                  cnt_r      <= cnt_r + 4'd1;
               end
            end
            ST_FINISH: begin
               // A start seen here is dropped; the next one is taken in IDLE.
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r   <= ST_IDLE;
               cnt_r     <= 4'd0;
               busy_r    <= 1'b0;
               address_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy                = busy_r;
   assign done                = done_r;
   assign id_ok               = id_ok_r;
   assign ts_ok               = ts_ok_r;
   assign id_value            = id_value_r;
   assign ts_value            = ts_value_r;
   assign sysid.sysid_address = address_r;

`ifdef SYSID_CHECK_IRQ_EN
   logic irq_r;
   logic irq_set_s;

   // A mismatch is flagged at the same edge that raises done.
   always_comb begin
      irq_set_s = (ts_sample_s && (!id_ok_next_s || !ts_ok_next_s)) ? 1'b1 : 1'b0;
   end

   // Level mismatch interrupt: a new set wins over a coincident clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         irq_r <= 1'b0;
      end else if (irq_set_s) begin
         irq_r <= 1'b1;
      end else if (irq_clear) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= irq_r;
      end
   end

   assign irq = irq_r;
`endif

endmodule : nios_system_sysid_checker

// File: tb/tb_nios_system_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_nios_system_sysid_checker
// Two checker instances: A (AUTO_START=1, READ_LATENCY=0) and
// B (AUTO_START=0, READ_LATENCY=3). Expected results are queued when a check
// is started and compared when done pulses. Build with +define+SYSID_CHECK_IRQ_EN
// to include the interrupt checks.
// ---------------------------------------------------------------------------
module tb_nios_system_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1346454757;

   typedef struct {
      logic        id_ok;
      logic        ts_ok;
      logic [31:0] id_v;
      logic [31:0] ts_v;
      logic        irq;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_a_n, rst_b_n, start_a, start_b;
   logic        busy_a, done_a, id_ok_a, ts_ok_a;
   logic        busy_b, done_b, id_ok_b, ts_ok_b;
   logic [31:0] id_value_a, ts_value_a, id_value_b, ts_value_b;
   logic [31:0] id_word_a, ts_word_a, id_word_b, ts_word_b;
`ifdef SYSID_CHECK_IRQ_EN
   logic        irq_a, irq_b, irq_clear_a, irq_clear_b;
`endif
   logic        irq_m_a = 1'b0;
   logic        irq_m_b = 1'b0;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   nios_system_sysid_checker_if bus_a ();
   nios_system_sysid_checker_if bus_b ();

   nios_system_sysid_checker #(.READ_LATENCY(0), .AUTO_START(1'b1)) dut_a (
      .clock(clk), .reset_n(rst_a_n), .start(start_a), .busy(busy_a), .done(done_a),
      .id_ok(id_ok_a), .ts_ok(ts_ok_a), .id_value(id_value_a), .ts_value(ts_value_a),
      .sysid(bus_a)
`ifdef SYSID_CHECK_IRQ_EN
      , .irq(irq_a), .irq_clear(irq_clear_a)
`endif
   );

   nios_system_sysid_checker #(.READ_LATENCY(3), .AUTO_START(1'b0)) dut_b (
      .clock(clk), .reset_n(rst_b_n), .start(start_b), .busy(busy_b), .done(done_b),
      .id_ok(id_ok_b), .ts_ok(ts_ok_b), .id_value(id_value_b), .ts_value(ts_value_b),
      .sysid(bus_b)
`ifdef SYSID_CHECK_IRQ_EN
      , .irq(irq_b), .irq_clear(irq_clear_b)
`endif
   );

   always #5 clk = ~clk;

   // Slave A: zero-latency sysid slave.
   always_comb bus_a.sysid_readdata = bus_a.sysid_address ? ts_word_a : id_word_a;

   // Slave B: data only valid once the address has been stable for 3 cycles.
   logic [3:0] age_b       = 4'd15;
   logic       prev_addr_b = 1'b0;
   always @(negedge clk) begin
      if (bus_b.sysid_address != prev_addr_b) age_b <= 4'd0;
      else if (age_b != 4'd15)                age_b <= age_b + 4'd1;
      prev_addr_b <= bus_b.sysid_address;
   end
   always_comb bus_b.sysid_readdata = (age_b >= 4'd3) ?
      (bus_b.sysid_address ? ts_word_b : id_word_b) : 32'hDEAD_BEEF;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic sel_done(input bit which);
      return which ? done_b : done_a;
   endfunction
   function automatic logic sel_busy(input bit which);
      return which ? busy_b : busy_a;
   endfunction
   function automatic logic sel_addr(input bit which);
      return which ? bus_b.sysid_address : bus_a.sysid_address;
   endfunction

   task automatic set_start(input bit which, input logic v);
      if (which) start_b = v;
      else       start_a = v;
   endtask

   function automatic exp_t model(input bit which);
      exp_t e;
      e.id_v  = which ? id_word_b : id_word_a;
      e.ts_v  = which ? ts_word_b : ts_word_a;
      e.id_ok = (e.id_v == EXP_ID);
      e.ts_ok = (e.ts_v == EXP_TS);
      e.irq   = (which ? irq_m_b : irq_m_a) | ~(e.id_ok & e.ts_ok);
      return e;
   endfunction

   task automatic push_exp(input bit which);
      exp_t e;
      e = model(which);
      if (which) begin q_b.push_back(e); irq_m_b = e.irq; end
      else       begin q_a.push_back(e); irq_m_a = e.irq; end
   endtask

   task automatic check_zero(input bit which, input string pfx);
      check_val({pfx, "_busy"},  which ? busy_b : busy_a, 32'd0);
      check_val({pfx, "_done"},  which ? done_b : done_a, 32'd0);
      check_val({pfx, "_id_ok"}, which ? id_ok_b : id_ok_a, 32'd0);
      check_val({pfx, "_ts_ok"}, which ? ts_ok_b : ts_ok_a, 32'd0);
      check_val({pfx, "_idv"},   which ? id_value_b : id_value_a, 32'd0);
      check_val({pfx, "_tsv"},   which ? ts_value_b : ts_value_a, 32'd0);
      check_val({pfx, "_addr"},  sel_addr(which), 32'd0);
`ifdef SYSID_CHECK_IRQ_EN
      check_val({pfx, "_irq"},   which ? irq_b : irq_a, 32'd0);
`endif
   endtask

   // Start a check at a negedge, follow it to done, check latency, the
   // cleared results, and that the FSM is back in IDLE afterwards.
   task automatic run_check(input bit which, input bit spam, input int exp_lat,
                            output logic [15:0] hist);
      int n;
      push_exp(which);
      set_start(which, 1'b1);
      @(posedge clk); @(negedge clk);
      n = 1;
      hist = 16'd0;
      hist[0] = sel_addr(which);
      check_val("run_busy",    sel_busy(which), 32'd1);
      check_val("clr_id_ok",   which ? id_ok_b : id_ok_a, 32'd0);
      check_val("clr_ts_ok",   which ? ts_ok_b : ts_ok_a, 32'd0);
      check_val("clr_id_val",  which ? id_value_b : id_value_a, 32'd0);
      check_val("clr_ts_val",  which ? ts_value_b : ts_value_a, 32'd0);
      while (!sel_done(which) && n < 40) begin
         set_start(which, spam);
         @(posedge clk); @(negedge clk);
         n++;
         if (n <= 16) hist[n-1] = sel_addr(which);
      end
      check_val("done_latency", n, exp_lat);
      set_start(which, spam);
      @(posedge clk); @(negedge clk);
      set_start(which, 1'b0);
      check_val("idle_after", sel_busy(which), 32'd0);
   endtask

   // Scoreboard: compare DUT results against the queued expectation at done.
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (done_a === 1'b1) begin
         if (q_a.size() == 0) check_val("a_spurious_done", 32'd1, 32'd0);
         else begin
            e = q_a.pop_front();
            check_val("a_id_ok", id_ok_a, e.id_ok);
            check_val("a_ts_ok", ts_ok_a, e.ts_ok);
            check_val("a_id_val", id_value_a, e.id_v);
            check_val("a_ts_val", ts_value_a, e.ts_v);
`ifdef SYSID_CHECK_IRQ_EN
            check_val("a_irq", irq_a, e.irq);
`endif
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (done_b === 1'b1) begin
         if (q_b.size() == 0) check_val("b_spurious_done", 32'd1, 32'd0);
         else begin
            e = q_b.pop_front();
            check_val("b_id_ok", id_ok_b, e.id_ok);
            check_val("b_ts_ok", ts_ok_b, e.ts_ok);
            check_val("b_id_val", id_value_b, e.id_v);
            check_val("b_ts_val", ts_value_b, e.ts_v);
`ifdef SYSID_CHECK_IRQ_EN
            check_val("b_irq", irq_b, e.irq);
`endif
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [15:0] hist;
      logic [8:0]  seq;
      int          n;
      rst_a_n = 1'b0; rst_b_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
`ifdef SYSID_CHECK_IRQ_EN
      irq_clear_a = 1'b0; irq_clear_b = 1'b0;
`endif
      id_word_a = EXP_ID; ts_word_a = EXP_TS;
      id_word_b = EXP_ID; ts_word_b = 32'h1234_5678;

      @(negedge clk);
      check_zero(1'b0, "a_rst");
      check_zero(1'b1, "b_rst");

      // Auto-start after reset: done in the 4th cycle (3 edges after release).
      push_exp(1'b0);
      rst_a_n = 1'b1; rst_b_n = 1'b1;
      n = 0;
      while (!done_a && n < 10) begin
         @(posedge clk); @(negedge clk);
         n++;
         if (n == 1) check_val("a_auto_busy", busy_a, 32'd1);
      end
      check_val("a_auto_edges", n, 32'd3);
      check_val("b_no_autostart", busy_b, 32'd0);
      @(posedge clk); @(negedge clk);
      check_val("a_auto_idle", busy_a, 32'd0);
      check_val("a_addr_hold", bus_a.sysid_address, 32'd1);

      // B: latency 3, timestamp mismatch; done 9 cycles after start.
      run_check(1'b1, 1'b0, 9, hist);
      // B: start spammed while busy and in FINISH; one done, address 0x4 then 1x5.
      run_check(1'b1, 1'b1, 9, hist);
      seq = hist[8:0];
      check_val("b_addr_seq", seq, 9'h1F0);
      // B: ID mismatch.
      id_word_b = 32'h0000_0001;
      run_check(1'b1, 1'b0, 9, hist);
      id_word_b = EXP_ID;

      // A: start held through FINISH is ignored, then back-to-back accepted.
      run_check(1'b0, 1'b1, 3, hist);
      run_check(1'b0, 1'b0, 3, hist);
      // A: single-bit differences in either word.
      id_word_a = 32'h8000_0000;
      run_check(1'b0, 1'b0, 3, hist);
      id_word_a = EXP_ID; ts_word_a = EXP_TS ^ 32'h0000_0001;
      run_check(1'b0, 1'b0, 3, hist);
      ts_word_a = EXP_TS;

      // A: reset in RD_TS aborts; auto-start then runs a fresh full check.
      set_start(1'b0, 1'b1);
      @(posedge clk); @(negedge clk);
      set_start(1'b0, 1'b0);
      @(posedge clk); @(negedge clk);
      check_val("a_rdts_addr", bus_a.sysid_address, 32'd1);
      rst_a_n = 1'b0;
      #1;
      check_zero(1'b0, "a_abort");
      irq_m_a = 1'b0;
      @(negedge clk);
      push_exp(1'b0);
      rst_a_n = 1'b1;
      n = 0;
      while (!done_a && n < 10) begin
         @(posedge clk); @(negedge clk);
         n++;
      end
      check_val("a_restart_edges", n, 32'd3);
      @(posedge clk); @(negedge clk);

`ifdef SYSID_CHECK_IRQ_EN
      // Level irq held, cleared by a pulse, and set winning over a clear.
      check_val("b_irq_level", irq_b, 32'd1);
      irq_clear_b = 1'b1;
      @(posedge clk); @(negedge clk);
      irq_clear_b = 1'b0;
      irq_m_b = 1'b0;
      check_val("b_irq_cleared", irq_b, 32'd0);
      irq_clear_b = 1'b1;
      run_check(1'b1, 1'b0, 9, hist);
      check_val("b_irq_clear_after", irq_b, 32'd0);
      irq_clear_b = 1'b0;
      irq_m_b = 1'b0;
`endif

      repeat (5) @(negedge clk);
      check_val("a_queue_empty", q_a.size(), 32'd0);
      check_val("b_queue_empty", q_b.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_nios_system_sysid_checker
